// File: rtl/ov_line_buf_ctrl.sv
// ov_line_buf_ctrl: camera line FIFO sequencer with line admission, short-line padding and a 2-entry output skid buffer
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   vsync, href, pix_valid, pix camera capture side
//   fifo_*                      1-bit line FIFO control (read data valid 1 cycle after fifo_rd_en)
//   out_valid/ready/data/sol/eol  pixel stream to the consumer
//   line_drop, err_short, err_full  drop pulse and sticky error flags
module ov_line_buf_ctrl #(
  parameter int LINE_LEN = 640,
  parameter int FIFO_CAP = 1024,
  parameter int CNT_W    = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  input  logic href,
  input  logic pix_valid,
  input  logic pix,
  output logic fifo_wr_en,
  output logic fifo_din,
  input  logic fifo_full,
  output logic fifo_rd_en,
  input  logic fifo_dout,
  input  logic fifo_empty,
  output logic fifo_rst_n,
  output logic out_valid,
  output logic out_data,
  output logic out_sol,
  output logic out_eol,
  input  logic out_ready,
  output logic line_drop,
  output logic err_short,
  output logic err_full
);
  typedef enum logic [1:0] {W_IDLE, W_LINE, W_PAD, W_DROP} w_state_t;
  typedef enum logic {R_IDLE, R_LINE} r_state_t;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0] ADM_MAX = CNT_W'(FIFO_CAP - 1 - LINE_LEN);
  w_state_t ws;
  r_state_t rs;
  logic vsync_q, href_q, inflight, in_sol, in_eol;
  logic [CNT_W-1:0] occ, lines_rdy, wcnt, rcnt;
  logic [1:0] skid_occ;
  logic [2:0] e0, e1;
  logic vs_rise, clr, h_rise, pix_in, w_done, r_take, pop;
  assign vs_rise    = vsync & ~vsync_q;
  assign clr        = vs_rise | fifo_full;
  assign h_rise     = href & ~href_q;
  assign pix_in     = pix_valid & href;
  assign fifo_wr_en = !clr && ((ws == W_LINE && pix_in) || ws == W_PAD);
  assign fifo_din   = ws == W_LINE && pix;
  assign w_done     = fifo_wr_en && wcnt == LAST;
  assign pop        = out_valid & out_ready;
  // Space is judged after this cycle's pop so a steady stream reads every cycle.
  assign fifo_rd_en = !clr && rs == R_LINE && !fifo_empty && rcnt <= LAST &&
                      ({1'b0, skid_occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
  assign r_take     = !clr && rs == R_IDLE && lines_rdy != '0;
  assign out_valid  = skid_occ != 2'd0;
  assign out_data   = e0[2];
  assign out_sol    = e0[1];
  assign out_eol    = e0[0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws <= W_IDLE;
      rs <= R_IDLE;
      vsync_q <= 1'b0;
      href_q <= 1'b0;
      inflight <= 1'b0;
      in_sol <= 1'b0;
      in_eol <= 1'b0;
      occ <= '0;
      lines_rdy <= '0;
      wcnt <= '0;
      rcnt <= '0;
      skid_occ <= 2'd0;
      e0 <= 3'd0;
      e1 <= 3'd0;
      fifo_rst_n <= 1'b1;
      line_drop <= 1'b0;
      err_short <= 1'b0;
      err_full <= 1'b0;
    end else begin
      vsync_q <= vsync;
      href_q <= href;
      fifo_rst_n <= !vs_rise;
      line_drop <= 1'b0;
      in_sol <= rcnt == '0;
      in_eol <= rcnt == LAST;
      if (clr) begin
        ws <= W_IDLE;
        rs <= R_IDLE;
        occ <= '0;
        lines_rdy <= '0;
        wcnt <= '0;
        rcnt <= '0;
        skid_occ <= 2'd0;
        inflight <= 1'b0;
        err_full <= !vs_rise;
        if (vs_rise) err_short <= 1'b0;
      end else begin
        occ <= occ + CNT_W'(fifo_wr_en) - CNT_W'(fifo_rd_en);
        lines_rdy <= lines_rdy + CNT_W'(w_done) - CNT_W'(r_take);
        inflight <= fifo_rd_en;
        if (fifo_wr_en) wcnt <= w_done ? '0 : wcnt + 1'b1;
        case (ws)
          W_IDLE: if (h_rise) begin
            ws <= occ <= ADM_MAX ? W_LINE : W_DROP;
            line_drop <= occ > ADM_MAX;
          end
          W_LINE: if (w_done) ws <= W_IDLE;
            else if (!href) begin
              ws <= W_PAD;
              err_short <= 1'b1;
            end
          W_PAD: begin
            if (w_done) ws <= W_IDLE;
            if (pix_in) err_short <= 1'b1;
          end
          default: if (!href) ws <= W_IDLE;
        endcase
        if (r_take) begin
          rs <= R_LINE;
          rcnt <= '0;
        end else if (fifo_rd_en) begin
          rcnt <= rcnt + 1'b1;
          if (rcnt == LAST) rs <= R_IDLE;
        end
        skid_occ <= skid_occ + {1'b0, inflight} - {1'b0, pop};
        if (pop) e0 <= e1;
        // Arriving data lands in the first slot left free after the pop.
        if (inflight && skid_occ == {1'b0, pop}) e0 <= {fifo_dout, in_sol, in_eol};
        else if (inflight) e1 <= {fifo_dout, in_sol, in_eol};
      end
    end
  end
endmodule

// File: tb/tb_ov_line_buf_ctrl.sv
// tb_ov_line_buf_ctrl: directed bench with FIFO model and output scoreboard for ov_line_buf_ctrl
module tb_ov_line_buf_ctrl;
  localparam int L = 640;
  logic clk = 1'b0, rst_n = 1'b0, vsync = 1'b0, href = 1'b0, pix_valid = 1'b0, pix = 1'b0;
  logic fifo_dout = 1'b0, out_ready = 1'b0, force_full = 1'b0, rand_rdy = 1'b0, full_seen = 1'b0;
  logic fifo_full, fifo_empty, fifo_wr_en, fifo_din, fifo_rd_en, fifo_rst_n;
  logic out_valid, out_data, out_sol, out_eol, line_drop, err_short, err_full;
  int checks = 0, errors = 0, fsz = 0, drops = 0, cyc = 0, sol_cyc = 0, eol_cyc = 0, beat = 0;
  bit fq[$];
  logic [2:0] exq[$];
  logic [2:0] prev = 3'd0;
  logic prev_stall = 1'b0;
  always #5 clk = ~clk;
  ov_line_buf_ctrl dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .href(href), .pix_valid(pix_valid), .pix(pix),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rst_n(fifo_rst_n),
    .out_valid(out_valid), .out_data(out_data), .out_sol(out_sol), .out_eol(out_eol),
    .out_ready(out_ready), .line_drop(line_drop), .err_short(err_short), .err_full(err_full)
  );
  assign fifo_full  = force_full | (fsz >= 1024);
  assign fifo_empty = fsz == 0;
  // 1-bit FIFO model: registered read data, self-clears when full
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fsz <= 0;
    end else begin
      if (!fifo_rst_n || fifo_full) begin
        if (fsz >= 1024) full_seen <= 1'b1;
        fq.delete();
      end else begin
        if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
        if (fifo_wr_en) fq.push_back(fifo_din);
      end
      fsz <= fq.size();
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (line_drop) drops++;
    if (prev_stall) chk("stall_hold", {28'b0, out_valid, out_data, out_sol, out_eol}, {28'b0, 1'b1, prev});
    if (out_valid && out_ready) begin
      if (out_sol) begin
        sol_cyc = cyc;
        beat = 0;
      end
      if (out_eol) eol_cyc = cyc;
      beat++;
      if (exq.size() == 0) chk("extra_beat", {31'b0, out_valid}, 32'd0);
      else chk("beat", {29'b0, out_data, out_sol, out_eol}, {29'b0, exq.pop_front()});
    end
    prev_stall = out_valid && !out_ready;
    prev = {out_data, out_sol, out_eol};
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end
  task automatic send(input int n, input int pat, input bit adm);
    @(posedge clk);
    #1 href = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 pix_valid = 1'b1;
      pix = pat != 0 ? 1'($urandom_range(0, 1)) : (i % 2 == 0);
      if (adm) exq.push_back({pix, i == 0, i == L - 1});
    end
    @(posedge clk);
    #1 pix_valid = 1'b0;
    href = 1'b0;
    pix = 1'b0;
    if (adm) for (int i = n; i < L; i++) exq.push_back({1'b0, i == 0, i == L - 1});
  endtask
  task automatic drain();
    for (int i = 0; i < 5000 && exq.size() != 0; i++) @(posedge clk);
    chk("drain", exq.size(), 32'd0);
    repeat (20) @(posedge clk);
    #1;
  endtask
  task automatic wait_room();
    for (int i = 0; i < 4000 && fsz > 300; i++) @(posedge clk);
    chk("room", {31'b0, fsz <= 300}, 32'd1);
  endtask
  initial begin
    #23;
    chk("rst_valid", out_valid, 0);
    chk("rst_fifo_rst_n", fifo_rst_n, 1);
    chk("rst_errs", {err_short, err_full, line_drop}, 0);
    chk("rst_fifo_ctl", {fifo_wr_en, fifo_rd_en}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    send(L, 0, 1);
    drain();
    chk("t1_span", eol_cyc - sol_cyc, L - 1);
    chk("t1_empty", fifo_empty, 1);
    chk("t1_err_short", err_short, 0);
    out_ready = 1'b0;
    drops = 0;
    send(L, 0, 1);
    repeat (2) @(posedge clk);
    send(L, 1, 0);
    repeat (5) @(posedge clk);
    #1 chk("t2_drops", drops, 1);
    chk("t2_held_valid", out_valid, 1);
    out_ready = 1'b1;
    drain();
    chk("t2_no_full", {err_full, full_seen}, 0);
    chk("t2_empty", fifo_empty, 1);
    send(600, 1, 1);
    drain();
    chk("t3_err_short", err_short, 1);
    @(posedge clk);
    #1 vsync = 1'b1;
    @(posedge clk);
    #1 vsync = 1'b0;
    @(posedge clk);
    #1 chk("vs_clears_short", err_short, 0);
    rand_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_room();
      send(L, 1, 1);
      repeat ($urandom_range(5, 30)) @(posedge clk);
    end
    drain();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    chk("t4_empty", fifo_empty, 1);
    beat = 0;
    send(L, 0, 1);
    for (int i = 0; i < 2000 && beat < 300; i++) @(posedge clk);
    #1 vsync = 1'b1;
    @(posedge clk);
    #1 exq.delete();
    chk("t5_rst_low", fifo_rst_n, 0);
    chk("t5_valid_drop", out_valid, 0);
    vsync = 1'b0;
    @(posedge clk);
    #1 chk("t5_rst_high", fifo_rst_n, 1);
    send(L, 1, 1);
    drain();
    @(posedge clk);
    #1 href = 1'b1;
    for (int i = 0; i < L; i++) begin
      @(posedge clk);
      #1 pix_valid = 1'b1;
      pix = 1'(i % 2);
      force_full = i == 320;
      if (i == 321) chk("t6_no_fifo_rst", fifo_rst_n, 1);
    end
    @(posedge clk);
    #1 pix_valid = 1'b0;
    href = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("t6_err_full", err_full, 1);
    chk("t6_valid", out_valid, 0);
    chk("t6_empty", fifo_empty, 1);
    send(L, 1, 1);
    drain();
    chk("t6_err_full_sticky", err_full, 1);
    @(posedge clk);
    #1 href = 1'b1;
    repeat (50) begin
      @(posedge clk);
      #1 pix_valid = 1'b1;
      pix = 1'b1;
    end
    #3 rst_n = 1'b0;
    #1 chk("t7_wr_en", fifo_wr_en, 0);
    chk("t7_err_full", err_full, 0);
    chk("t7_fifo_rst_n", fifo_rst_n, 1);
    chk("t7_valid", out_valid, 0);
    pix_valid = 1'b0;
    href = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(L, 0, 1);
    drain();
    chk("t7_after_empty", fifo_empty, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
